// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage between fetch and dispatch.
// Fetched {instr, pc, pred_jump} are buffered in a DEPTH-entry FIFO; the head
// (or the incoming instruction when the FIFO is empty) is decoded into a
// registered output slot with a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy_i               global ready, 0 freezes all state
//   flush_i             synchronous flush of FIFO and output slot
//   if_*                fetch side: valid/ready, instruction, pc, predicted-taken
//   dec_*               decoded output slot: valid/ready handshake plus fields
//   count_o             FIFO occupancy, output slot excluded

package decode_queue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND
  } opcode_type_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_jump;
  } fetch_t;

  typedef struct packed {
    opcode_type_e     optype;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic             is_ls;
    logic             is_jump;
    logic             pred_jump;
    logic             illegal;
  } dec_t;

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy_i,
  input  logic                          flush_i,
  input  logic                          if_valid_i,
  input  logic [XLEN-1:0]               if_instr_i,
  input  logic [XLEN-1:0]               if_pc_i,
  input  logic                          if_pred_jump_i,
  output logic                          if_ready_o,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output decode_queue_pkg::opcode_type_e dec_optype_o,
  output logic [REG_W-1:0]              dec_rd_o,
  output logic [REG_W-1:0]              dec_rs1_o,
  output logic [REG_W-1:0]              dec_rs2_o,
  output logic [XLEN-1:0]               dec_imm_o,
  output logic [XLEN-1:0]               dec_pc_o,
  output logic                          dec_is_ls_o,
  output logic                          dec_is_jump_o,
  output logic                          dec_pred_jump_o,
  output logic                          dec_illegal_o,
  output logic [CNT_W-1:0]              count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // RV32I decoder; illegal encodings collapse to a NOP with rd/imm/flags zeroed.
  function automatic dec_t decode(input fetch_t f);
    dec_t        d;
    logic [31:0] i;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    i     = f.instr;
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    d           = '0;
    d.optype    = OP_NOP;
    d.rd        = i[11:7];
    d.rs1       = i[19:15];
    d.rs2       = i[24:20];
    d.pc        = f.pc;
    d.pred_jump = f.pred_jump;
    case (i[6:0])
      7'b0110111: begin d.optype = OP_LUI;   d.imm = imm_u; end
      7'b0010111: begin d.optype = OP_AUIPC; d.imm = imm_u; end
      7'b1101111: begin d.optype = OP_JAL;   d.imm = imm_j; d.is_jump = 1'b1; end
      7'b1100111: begin
        d.optype  = OP_JALR;
        d.imm     = imm_i;
        d.is_jump = 1'b1;
        d.illegal = (f3 != 3'b000);
      end
      7'b1100011: begin
        d.imm     = imm_b;
        d.rd      = '0;
        d.is_jump = 1'b1;
        case (f3)
          3'b000:  d.optype = OP_BEQ;
          3'b001:  d.optype = OP_BNE;
          3'b100:  d.optype = OP_BLT;
          3'b101:  d.optype = OP_BGE;
          3'b110:  d.optype = OP_BLTU;
          3'b111:  d.optype = OP_BGEU;
          default: d.illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        d.imm   = imm_i;
        d.is_ls = 1'b1;
        case (f3)
          3'b000:  d.optype = OP_LB;
          3'b001:  d.optype = OP_LH;
          3'b010:  d.optype = OP_LW;
          3'b100:  d.optype = OP_LBU;
          3'b101:  d.optype = OP_LHU;
          default: d.illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        d.imm   = imm_s;
        d.rd    = '0;
        d.is_ls = 1'b1;
        case (f3)
          3'b000:  d.optype = OP_SB;
          3'b001:  d.optype = OP_SH;
          3'b010:  d.optype = OP_SW;
          default: d.illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        d.imm = imm_i;
        case (f3)
          3'b000: d.optype = OP_ADDI;
          3'b010: d.optype = OP_SLTI;
          3'b011: d.optype = OP_SLTIU;
          3'b100: d.optype = OP_XORI;
          3'b110: d.optype = OP_ORI;
          3'b111: d.optype = OP_ANDI;
          3'b001: begin
            d.imm     = {27'b0, i[24:20]};
            d.optype  = OP_SLLI;
            d.illegal = (f7 != 7'b0000000);
          end
          default: begin
            d.imm = {27'b0, i[24:20]};
            if (f7 == 7'b0000000)      d.optype  = OP_SRLI;
            else if (f7 == 7'b0100000) d.optype  = OP_SRAI;
            else                       d.illegal = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        case ({f7, f3})
          10'b0000000_000: d.optype = OP_ADD;
          10'b0100000_000: d.optype = OP_SUB;
          10'b0000000_001: d.optype = OP_SLL;
          10'b0000000_010: d.optype = OP_SLT;
          10'b0000000_011: d.optype = OP_SLTU;
          10'b0000000_100: d.optype = OP_XOR;
          10'b0000000_101: d.optype = OP_SRL;
          10'b0100000_101: d.optype = OP_SRA;
          10'b0000000_110: d.optype = OP_OR;
          10'b0000000_111: d.optype = OP_AND;
          default:         d.illegal = 1'b1;
        endcase
      end
      7'b0001111: d.rd = '0;  // FENCE: legal, no architectural effect here
      default:    d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.optype  = OP_NOP;
      d.rd      = '0;
      d.imm     = '0;
      d.is_ls   = 1'b0;
      d.is_jump = 1'b0;
    end
    return d;
  endfunction

  fetch_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_valid_q, dec_valid_d;
  dec_t             dec_q, dec_d;

  fetch_t if_entry;
  fetch_t slot_src;
  dec_t   slot_dec;
  logic   push, slot_load, fifo_empty, pop, bypass, fifo_wr;

  assign if_entry   = '{instr: if_instr_i, pc: if_pc_i, pred_jump: if_pred_jump_i};
  // No pop-through when full: readiness depends only on current occupancy.
  assign if_ready_o = rdy_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign push       = if_valid_i && if_ready_o;
  assign slot_load  = rdy_i && !flush_i && (!dec_valid_q || dec_ready_i);
  assign fifo_empty = (count_q == '0);
  assign pop        = slot_load && !fifo_empty;
  assign bypass     = slot_load && fifo_empty && push;
  assign fifo_wr    = push && !bypass;

  // Single decoder shared by the FIFO head and the bypass path.
  assign slot_src = fifo_empty ? if_entry : mem_q[rd_ptr_q];
  assign slot_dec = decode(slot_src);

  // Next-state for pointers, occupancy and output slot.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;
    if (rdy_i && flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
    end else begin
      if (slot_load) begin
        if (pop || bypass) begin
          dec_d       = slot_dec;
          dec_valid_d = 1'b1;
        end else begin
          dec_valid_d = 1'b0;
        end
      end
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(fifo_wr) - CNT_W'(pop);
    end
  end

  // Control and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= if_entry;
  end

  assign dec_valid_o     = dec_valid_q;
  assign dec_optype_o    = dec_q.optype;
  assign dec_rd_o        = dec_q.rd;
  assign dec_rs1_o       = dec_q.rs1;
  assign dec_rs2_o       = dec_q.rs2;
  assign dec_imm_o       = dec_q.imm;
  assign dec_pc_o        = dec_q.pc;
  assign dec_is_ls_o     = dec_q.is_ls;
  assign dec_is_jump_o   = dec_q.is_jump;
  assign dec_pred_jump_o = dec_q.pred_jump;
  assign dec_illegal_o   = dec_q.illegal;
  assign count_o         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: directed scenarios plus randomized streaming,
// checked against a transaction-level queue model and a mask/match decode table.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy_i, flush_i, if_valid_i, if_pred_jump_i, dec_ready_i;
  logic [31:0] if_instr_i, if_pc_i;
  logic if_ready_o, dec_valid_o, dec_is_ls_o, dec_is_jump_o, dec_pred_jump_o, dec_illegal_o;
  opcode_type_e dec_optype_o;
  logic [4:0] dec_rd_o, dec_rs1_o, dec_rs2_o;
  logic [31:0] dec_imm_o, dec_pc_o;
  logic [CNT_W-1:0] count_o;

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_i(rdy_i), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .if_pred_jump_i(if_pred_jump_i), .if_ready_o(if_ready_o),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_optype_o(dec_optype_o),
    .dec_rd_o(dec_rd_o), .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o),
    .dec_imm_o(dec_imm_o), .dec_pc_o(dec_pc_o), .dec_is_ls_o(dec_is_ls_o),
    .dec_is_jump_o(dec_is_jump_o), .dec_pred_jump_o(dec_pred_jump_o),
    .dec_illegal_o(dec_illegal_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  dec_t got;
  assign got = {dec_optype_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_imm_o, dec_pc_o,
                dec_is_ls_o, dec_is_jump_o, dec_pred_jump_o, dec_illegal_o};

  int total = 0;
  int bad   = 0;

  // ---------------- reference decoder: mask/match rule table ----------------
  typedef enum {F_U, F_J, F_I, F_B, F_S, F_SH, F_R, F_N} fmt_e;
  typedef struct {
    logic [31:0]  mask;
    logic [31:0]  match;
    opcode_type_e op;
    fmt_e         fmt;
    bit           ls;
    bit           jmp;
  } rule_t;
  rule_t rules[$];

  task automatic add_rule(input logic [31:0] m, input logic [31:0] x, input opcode_type_e op,
                          input fmt_e f, input bit ls, input bit jmp);
    rule_t r;
    r.mask = m; r.match = x; r.op = op; r.fmt = f; r.ls = ls; r.jmp = jmp;
    rules.push_back(r);
  endtask

  task automatic build_rules();
    add_rule(32'h7F, 32'h37, OP_LUI, F_U, 0, 0);
    add_rule(32'h7F, 32'h17, OP_AUIPC, F_U, 0, 0);
    add_rule(32'h7F, 32'h6F, OP_JAL, F_J, 0, 1);
    add_rule(32'h707F, 32'h67, OP_JALR, F_I, 0, 1);
    add_rule(32'h707F, 32'h0063, OP_BEQ, F_B, 0, 1);
    add_rule(32'h707F, 32'h1063, OP_BNE, F_B, 0, 1);
    add_rule(32'h707F, 32'h4063, OP_BLT, F_B, 0, 1);
    add_rule(32'h707F, 32'h5063, OP_BGE, F_B, 0, 1);
    add_rule(32'h707F, 32'h6063, OP_BLTU, F_B, 0, 1);
    add_rule(32'h707F, 32'h7063, OP_BGEU, F_B, 0, 1);
    add_rule(32'h707F, 32'h0003, OP_LB, F_I, 1, 0);
    add_rule(32'h707F, 32'h1003, OP_LH, F_I, 1, 0);
    add_rule(32'h707F, 32'h2003, OP_LW, F_I, 1, 0);
    add_rule(32'h707F, 32'h4003, OP_LBU, F_I, 1, 0);
    add_rule(32'h707F, 32'h5003, OP_LHU, F_I, 1, 0);
    add_rule(32'h707F, 32'h0023, OP_SB, F_S, 1, 0);
    add_rule(32'h707F, 32'h1023, OP_SH, F_S, 1, 0);
    add_rule(32'h707F, 32'h2023, OP_SW, F_S, 1, 0);
    add_rule(32'h707F, 32'h0013, OP_ADDI, F_I, 0, 0);
    add_rule(32'h707F, 32'h2013, OP_SLTI, F_I, 0, 0);
    add_rule(32'h707F, 32'h3013, OP_SLTIU, F_I, 0, 0);
    add_rule(32'h707F, 32'h4013, OP_XORI, F_I, 0, 0);
    add_rule(32'h707F, 32'h6013, OP_ORI, F_I, 0, 0);
    add_rule(32'h707F, 32'h7013, OP_ANDI, F_I, 0, 0);
    add_rule(32'hFE00707F, 32'h00001013, OP_SLLI, F_SH, 0, 0);
    add_rule(32'hFE00707F, 32'h00005013, OP_SRLI, F_SH, 0, 0);
    add_rule(32'hFE00707F, 32'h40005013, OP_SRAI, F_SH, 0, 0);
    add_rule(32'hFE00707F, 32'h00000033, OP_ADD, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h40000033, OP_SUB, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00001033, OP_SLL, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00002033, OP_SLT, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00003033, OP_SLTU, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00004033, OP_XOR, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00005033, OP_SRL, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h40005033, OP_SRA, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00006033, OP_OR, F_R, 0, 0);
    add_rule(32'hFE00707F, 32'h00007033, OP_AND, F_R, 0, 0);
    add_rule(32'h7F, 32'h0F, OP_NOP, F_N, 0, 0);
  endtask

  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic pj);
    dec_t d;
    int   hit;
    int   v;
    hit = -1;
    foreach (rules[k]) if (hit < 0 && (ins & rules[k].mask) == rules[k].match) hit = k;
    d = '0;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.pc = pc;
    d.pred_jump = pj;
    if (hit < 0) begin
      d.illegal = 1'b1;
      return d;
    end
    d.optype  = rules[hit].op;
    d.is_ls   = rules[hit].ls;
    d.is_jump = rules[hit].jmp;
    d.rd      = ins[11:7];
    v = 0;
    case (rules[hit].fmt)
      F_U: v = int'(ins & 32'hFFFFF000);
      F_J: begin
        v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) v = v - 1048576;
      end
      F_I: begin
        v = int'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      F_S: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
        d.rd = 5'd0;
      end
      F_B: begin
        v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) v = v - 4096;
        d.rd = 5'd0;
      end
      F_SH: v = int'(ins[24:20]);
      F_R:  v = 0;
      default: d.rd = 5'd0;
    endcase
    d.imm = 32'(v);
    return d;
  endfunction

  // ---------------- transaction-level queue model ----------------
  fetch_t m_fifo[$];
  bit     m_valid;
  dec_t   m_dec;

  function automatic bit exp_if_ready();
    return rdy_i && !flush_i && (m_fifo.size() != int'(DEPTH));
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_valid = 1'b0;
    m_dec = '0;
  endtask

  // Applies one clock edge to the model using the current inputs, then advances the DUT.
  task automatic step();
    fetch_t in, h;
    bit push, load;
    in = '{instr: if_instr_i, pc: if_pc_i, pred_jump: if_pred_jump_i};
    if (rdy_i) begin
      if (flush_i) begin
        m_fifo.delete();
        m_valid = 1'b0;
      end else begin
        push = if_valid_i && (m_fifo.size() != int'(DEPTH));
        load = !m_valid || dec_ready_i;
        if (load) begin
          if (m_fifo.size() > 0) begin
            h = m_fifo.pop_front();
            m_dec = ref_decode(h.instr, h.pc, h.pred_jump);
            m_valid = 1'b1;
          end else if (push) begin
            m_dec = ref_decode(in.instr, in.pc, in.pred_jump);
            m_valid = 1'b1;
            push = 1'b0;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (push) m_fifo.push_back(in);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit pj,
                     input bit dr, input bit fl, input bit r);
    if_valid_i = v; if_instr_i = ins; if_pc_i = pc; if_pred_jump_i = pj;
    dec_ready_i = dr; flush_i = fl; rdy_i = r;
  endtask

  function automatic logic [31:0] rand_instr();
    rule_t r;
    if ($urandom_range(0, 3) == 0) return $urandom();
    r = rules[$urandom_range(0, rules.size() - 1)];
    return ($urandom() & ~r.mask) | r.match;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 32'h0, 32'h0, 0, 0, 0, 1);
    model_reset();
    #12;
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dec_valid_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (got !== dec_t'(0)) begin bad++; $display("FAIL reset_data got=%h exp=0", got); end
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%b exp=1", if_ready_o); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi();
    drv(1, 32'hFFB00093, 32'h100, 0, 1, 0, 1);
    step();
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    total++; if (dec_valid_o !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", dec_valid_o); end
    total++; if (dec_optype_o !== OP_ADDI) begin bad++; $display("FAIL addi_optype got=%0d exp=%0d", dec_optype_o, OP_ADDI); end
    total++; if (dec_rd_o !== 5'd1 || dec_rs1_o !== 5'd0) begin bad++; $display("FAIL addi_regs rd=%0d rs1=%0d exp rd=1 rs1=0", dec_rd_o, dec_rs1_o); end
    total++; if (dec_imm_o !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_imm got=%h exp=fffffffb", dec_imm_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL addi_count got=%0d exp=0", count_o); end
    total++; if (got !== m_dec) begin bad++; $display("FAIL addi_model got=%h exp=%h", got, m_dec); end
    step();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", dec_valid_o); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] pcs[6];
    for (int k = 0; k < 6; k++) pcs[k] = 32'h200 + 32'(4 * k);
    for (int k = 0; k < 5; k++) begin
      drv(1, rand_instr(), pcs[k], k[0], 0, 0, 1);
      #1;
      total++; if (if_ready_o !== exp_if_ready()) begin bad++; $display("FAIL fill_if_ready k=%0d got=%b exp=%b", k, if_ready_o, exp_if_ready()); end
      step();
    end
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count_o); end
    total++; if (dec_valid_o !== 1'b1 || dec_pc_o !== pcs[0]) begin bad++; $display("FAIL fill_slot valid=%b pc=%h exp pc=%h", dec_valid_o, dec_pc_o, pcs[0]); end
    drv(1, 32'h00000033, pcs[5], 0, 0, 0, 1);
    #1;
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL full_if_ready got=%b exp=0", if_ready_o); end
    step();
    total++; if (got !== m_dec || dec_pc_o !== pcs[0]) begin bad++; $display("FAIL stall_stable got=%h exp=%h", got, m_dec); end
    // Release: full FIFO still refuses input on the popping cycle.
    drv(1, 32'h00000033, pcs[5], 0, 1, 0, 1);
    #1;
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL full_pop_if_ready got=%b exp=0", if_ready_o); end
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    for (int k = 1; k < 5; k++) begin
      step();
      total++; if (dec_valid_o !== 1'b1 || dec_pc_o !== pcs[k] || got !== m_dec) begin bad++; $display("FAIL drain_order k=%0d pc=%h exp=%h", k, dec_pc_o, pcs[k]); end
      total++; if (count_o !== CNT_W'(4 - k)) begin bad++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count_o, 4 - k); end
    end
    step();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", dec_valid_o); end
  endtask

  task automatic test_decode_vectors();
    logic [31:0]  ins[5]  = '{32'h00000000, 32'h02000033, 32'h0000000F, 32'hFE208EE3, 32'h0020A423};
    bit           ill[5]  = '{1, 1, 0, 0, 0};
    opcode_type_e op[5]   = '{OP_NOP, OP_NOP, OP_NOP, OP_BEQ, OP_SW};
    bit           jmp[5]  = '{0, 0, 0, 1, 0};
    bit           ls[5]   = '{0, 0, 0, 0, 1};
    logic [31:0]  imm[5]  = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8};
    for (int k = 0; k < 5; k++) begin
      drv(1, ins[k], 32'h400 + 32'(4 * k), 1, 1, 0, 1);
      step();
      total++;
      if (dec_valid_o !== 1'b1 || dec_illegal_o !== ill[k] || dec_optype_o !== op[k] || dec_rd_o !== 5'd0 ||
          dec_is_jump_o !== jmp[k] || dec_is_ls_o !== ls[k]) begin
        bad++;
        $display("FAIL decode_vec k=%0d ill=%b op=%0d rd=%0d j=%b ls=%b exp ill=%b op=%0d rd=0 j=%b ls=%b",
                 k, dec_illegal_o, dec_optype_o, dec_rd_o, dec_is_jump_o, dec_is_ls_o, ill[k], op[k], jmp[k], ls[k]);
      end
      if (k != 2) begin
        total++; if (dec_imm_o !== imm[k]) begin bad++; $display("FAIL decode_imm k=%0d got=%h exp=%h", k, dec_imm_o, imm[k]); end
      end
      total++; if (got !== m_dec) begin bad++; $display("FAIL decode_model k=%0d got=%h exp=%h", k, got, m_dec); end
    end
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int k = 0; k < 8; k++) begin
      pc = 32'h800 + 32'(4 * k);
      drv(1, rand_instr(), pc, 0, 1, 0, 1);
      step();
      total++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== pc || count_o !== 3'd0 || got !== m_dec) begin
        bad++;
        $display("FAIL b2b k=%0d valid=%b pc=%h cnt=%0d exp pc=%h", k, dec_valid_o, dec_pc_o, count_o, pc);
      end
    end
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    step();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h00000033, 32'h500 + 32'(4 * k), 0, 0, 0, 1);
      step();
    end
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
    drv(1, 32'h00500093, 32'hDEAD0000, 0, 1, 1, 1);
    #1;
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL flush_if_ready got=%b exp=0", if_ready_o); end
    step();
    total++; if (count_o !== 3'd0 || dec_valid_o !== 1'b0) begin bad++; $display("FAIL flush_clear cnt=%0d valid=%b exp 0/0", count_o, dec_valid_o); end
    drv(1, 32'h00700113, 32'h300, 0, 1, 0, 1);
    step();
    total++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h300 || got !== m_dec) begin bad++; $display("FAIL flush_after pc=%h exp=300", dec_pc_o); end
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    step();
  endtask

  task automatic test_stall_reset();
    bit r;
    for (int c = 0; c < 12; c++) begin
      r = !(c >= 4 && c <= 6);
      drv(1, rand_instr(), 32'h600 + 32'(4 * c), 0, (c % 3) != 0, 0, r);
      #1;
      total++; if (if_ready_o !== exp_if_ready()) begin bad++; $display("FAIL stall_if_ready c=%0d got=%b exp=%b", c, if_ready_o, exp_if_ready()); end
      step();
      total++;
      if (count_o !== CNT_W'(m_fifo.size()) || dec_valid_o !== m_valid || (m_valid && got !== m_dec)) begin
        bad++;
        $display("FAIL stall_state c=%0d cnt=%0d valid=%b data=%h exp cnt=%0d valid=%b data=%h",
                 c, count_o, dec_valid_o, got, m_fifo.size(), m_valid, m_dec);
      end
    end
    drv(1, rand_instr(), 32'h700, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (dec_valid_o !== 1'b0 || count_o !== 3'd0) begin bad++; $display("FAIL async_reset valid=%b cnt=%0d exp 0/0", dec_valid_o, count_o); end
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 32'h0, 32'h0, 0, 1, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      drv($urandom_range(0, 9) < 7, rand_instr(), $urandom(), 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 9) != 0);
      #1;
      total++; if (if_ready_o !== exp_if_ready()) begin bad++; $display("FAIL rand_if_ready c=%0d got=%b exp=%b", c, if_ready_o, exp_if_ready()); end
      step();
      total++;
      if (count_o !== CNT_W'(m_fifo.size()) || dec_valid_o !== m_valid || (m_valid && got !== m_dec)) begin
        bad++;
        $display("FAIL rand_state c=%0d cnt=%0d valid=%b data=%h exp cnt=%0d valid=%b data=%h",
                 c, count_o, dec_valid_o, got, m_fifo.size(), m_valid, m_dec);
      end
    end
  endtask

  initial begin
    build_rules();
    test_reset();
    test_addi();
    test_fill_drain();
    test_decode_vectors();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
